uart_tx_sequencer: RTL and testbench

Controller between the UART transmit FIFO and the byte-wide UART transmitter. It pops 32-bit store words from the FIFO and splits each one into 1, 2 or 4 bytes according to the stored store-strobe code. It then issues bytes LSB-first to the transmitter using a start/busy handshake. It tracks progress and flags a transmitter that never acknowledges a start.

---
 rtl/uart_tx_sequencer.sv | 141 ++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// Pops 32-bit words from the UART TX FIFO and feeds their 1/2/4 valid bytes, LSB first,
// to a byte-wide transmitter over a start/busy handshake, with an acknowledge timeout.
module uart_tx_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic [1:0]        fifo_rd_strb,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              word_done,
  output logic              tx_err,
  input  logic              err_clr,
  output logic              idle,
  output logic [CNT_W-1:0]  bytes_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  localparam logic [3:0] ACK_LIM = 4'(ACK_TIMEOUT);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        remaining_q, remaining_d;
  logic [3:0]        tmo_q, tmo_d;
  logic              word_done_q, word_done_d;
  logic              tx_err_q, tx_err_d;
  logic [CNT_W-1:0]  bytes_sent_q, bytes_sent_d;
  logic              err_set;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    remaining_d  = remaining_q;
    tmo_d        = tmo_q;
    bytes_sent_d = bytes_sent_q;
    word_done_d  = 1'b0;
    err_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) state_d = S_POP;
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = fifo_rd_data;
        case (fifo_rd_strb)
          2'b01:   remaining_d = 3'd1;
          2'b10:   remaining_d = 3'd2;
          default: remaining_d = 3'd4;
        endcase
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tmo_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 4'd1;
          // Unacknowledged start: abandon the rest of this word without counting it.
          if (tmo_q + 4'd1 == ACK_LIM) begin
            err_set     = 1'b1;
            remaining_d = '0;
            state_d     = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          bytes_sent_d = bytes_sent_q + 1'b1;
          shift_d      = {8'h00, shift_q[DATA_W-1:8]};
          remaining_d  = remaining_q - 3'd1;
          if (remaining_q == 3'd1) begin
            word_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new timeout in the same cycle as err_clr keeps the flag set.
    if (err_set)      tx_err_d = 1'b1;
    else if (err_clr) tx_err_d = 1'b0;
    else              tx_err_d = tx_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      remaining_q  <= '0;
      tmo_q        <= '0;
      word_done_q  <= 1'b0;
      tx_err_q     <= 1'b0;
      bytes_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      remaining_q  <= remaining_d;
      tmo_q        <= tmo_d;
      word_done_q  <= word_done_d;
      tx_err_q     <= tx_err_d;
      bytes_sent_q <= bytes_sent_d;
    end
  end

  assign fifo_rd_en = (state_q == S_POP);
  assign idle       = (state_q == S_IDLE);
  assign tx_byte    = shift_q[7:0];
  assign tx_start   = (state_q == S_SEND) && !tx_busy;
  assign word_done  = word_done_q;
  assign tx_err     = tx_err_q;
  assign bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a FIFO model and a busy-pulse transmitter model.
module tb_uart_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic [1:0]  fifo_rd_strb;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic        word_done;
  logic        tx_err;
  logic        err_clr;
  logic        idle;
  logic [15:0] bytes_sent;

  uart_tx_sequencer #(.DATA_W(32), .ACK_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_strb(fifo_rd_strb),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy), .word_done(word_done),
    .tx_err(tx_err), .err_clr(err_clr), .idle(idle), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  localparam int BUSY_LEN = 10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  strb;
  } fent_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  strb;
    int          n;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  fent_t      fifo_q[$];
  logic [7:0] start_log[$];
  int         checks = 0;
  int         fails  = 0;
  int         viol   = 0;
  int         wd_cnt = 0;
  int         rd_cnt = 0;
  int         busy_cnt = 0;
  bit         start_pend = 0;
  bit         dead_tx = 0;
  bit         prev_start = 0;
  bit         prev_rd = 0;

  // FIFO and transmitter models plus protocol monitor, all on the falling edge.
  always @(negedge clk) begin
    bit    s;
    fent_t ent;
    s = tx_start;
    if (s) begin
      start_log.push_back(tx_byte);
      if (tx_busy) viol++;
      if (prev_start) viol++;
    end
    if (fifo_rd_en && prev_rd) viol++;
    if (word_done) wd_cnt++;
    if (fifo_rd_en) rd_cnt++;
    prev_start = s;
    prev_rd    = fifo_rd_en;
    if (fifo_rd_en) begin
      if (fifo_q.size() == 0) viol++;
      else begin
        ent = fifo_q.pop_front();
        fifo_rd_data = ent.data;
        fifo_rd_strb = ent.strb;
      end
    end
    fifo_empty = (fifo_q.size() == 0);
    if (busy_cnt != 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end else if (start_pend && !dead_tx) begin
      tx_busy  = 1'b1;
      busy_cnt = BUSY_LEN;
    end
    start_pend = s;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] s);
    fent_t e;
    e.data = d;
    e.strb = s;
    fifo_q.push_back(e);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_wd(input int target);
    int k;
    k = 0;
    while (wd_cnt < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("word_done_wait", (wd_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_starts(input int target);
    int k;
    k = 0;
    while (start_log.size() < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("start_wait", (start_log.size() >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_c3(input logic [7:0] eb);
    @(negedge clk);
    chk("c1_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    chk("c2_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("c2_start", {31'd0, tx_start}, 32'd0);
    chk("c2_idle", {31'd0, idle}, 32'd0);
    @(negedge clk);
    chk("c3_start", {31'd0, tx_start}, 32'd1);
    chk("c3_byte", {24'd0, tx_byte}, {24'd0, eb});
  endtask

  task automatic chk_byte(input string name, input int idx, input logic [7:0] eb);
    if (idx < start_log.size()) chk(name, {24'd0, start_log[idx]}, {24'd0, eb});
    else chk(name, 32'hFFFF_FFFF, {24'd0, eb});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    chk({tag, "_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_byte"}, {24'd0, tx_byte}, 32'd0);
    chk({tag, "_wd"}, {31'd0, word_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, tx_err}, 32'd0);
    chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
    chk({tag, "_cnt"}, {16'd0, bytes_sent}, 32'd0);
  endtask

  vec_t        vecs[6];
  int          base, tgt, k, rd_base, wd_base;
  logic [15:0] exp_sent;
  logic [15:0] seen[$];
  logic [15:0] prev_cnt;
  logic [7:0]  e;

  initial begin
    vecs[0] = '{32'hA1B2C3D4, 2'b00, 4, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    vecs[1] = '{32'h00000055, 2'b01, 1, 8'h55, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{32'h0000BEEF, 2'b10, 2, 8'hEF, 8'hBE, 8'h00, 8'h00};
    vecs[3] = '{32'h12345678, 2'b11, 4, 8'h78, 8'h56, 8'h34, 8'h12};
    vecs[4] = '{32'hFFEEDDCC, 2'b01, 1, 8'hCC, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{32'hCAFE0102, 2'b10, 2, 8'h02, 8'h01, 8'h00, 8'h00};

    rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0; tx_busy = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0; fifo_rd_strb = '0;
    exp_sent = '0;
    #1;
    chk_reset_vals("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;

    // Table of single words
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      base = start_log.size();
      tgt = wd_cnt + 1;
      push(vecs[v].data, vecs[v].strb);
      wait_wd(tgt);
      repeat (2) @(negedge clk);
      exp_sent += 16'(vecs[v].n);
      chk("vec_nstarts", start_log.size() - base, vecs[v].n);
      for (int i = 0; i < vecs[v].n; i++) begin
        case (i)
          0: e = vecs[v].b0;
          1: e = vecs[v].b1;
          2: e = vecs[v].b2;
          default: e = vecs[v].b3;
        endcase
        chk_byte("vec_byte", base + i, e);
      end
      chk("vec_bytes_sent", {16'd0, bytes_sent}, {16'd0, exp_sent});
      chk("vec_idle", {31'd0, idle}, 32'd1);
    end

    // Back-to-back words, first-start latency, pop spacing after word_done
    @(negedge clk);
    base = start_log.size();
    tgt = wd_cnt + 2;
    push(32'h00000055, 2'b01);
    push(32'h0000BEEF, 2'b10);
    check_c3(8'h55);
    k = 0;
    while (!word_done && k < 200) begin @(negedge clk); k++; end
    chk("b2b_wd_seen", {31'd0, word_done}, 32'd1);
    @(negedge clk);
    chk("b2b_pop_after_wd", {31'd0, fifo_rd_en}, 32'd1);
    wait_wd(tgt);
    repeat (2) @(negedge clk);
    exp_sent += 16'd3;
    chk("b2b_nstarts", start_log.size() - base, 3);
    chk_byte("b2b_b0", base, 8'h55);
    chk_byte("b2b_b1", base + 1, 8'hEF);
    chk_byte("b2b_b2", base + 2, 8'hBE);
    chk("b2b_bytes_sent", {16'd0, bytes_sent}, {16'd0, exp_sent});

    // Acknowledge timeout
    dead_tx = 1'b1;
    @(negedge clk);
    base = start_log.size();
    wd_base = wd_cnt;
    push(32'h99887766, 2'b00);
    k = 0;
    while (!tx_start && k < 50) begin @(negedge clk); k++; end
    chk("tmo_start_seen", {31'd0, tx_start}, 32'd1);
    k = 0;
    while (!tx_err && k < 20) begin @(negedge clk); k++; end
    chk("tmo_latency", k, 5);
    chk("tmo_idle", {31'd0, idle}, 32'd1);
    repeat (3) @(negedge clk);
    chk("tmo_sticky", {31'd0, tx_err}, 32'd1);
    chk("tmo_no_wd", wd_cnt, wd_base);
    chk("tmo_nstarts", start_log.size() - base, 1);
    chk("tmo_bytes_sent", {16'd0, bytes_sent}, {16'd0, exp_sent});
    dead_tx = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, tx_err}, 32'd0);

    // Recovery word
    base = start_log.size();
    tgt = wd_cnt + 1;
    push(32'h00000304, 2'b10);
    wait_wd(tgt);
    repeat (2) @(negedge clk);
    exp_sent += 16'd2;
    chk_byte("rec_b0", base, 8'h04);
    chk_byte("rec_b1", base + 1, 8'h03);
    chk("rec_bytes_sent", {16'd0, bytes_sent}, {16'd0, exp_sent});
    chk("rec_err", {31'd0, tx_err}, 32'd0);

    // enable dropped during byte 2
    @(negedge clk);
    base = start_log.size();
    rd_base = rd_cnt;
    tgt = wd_cnt + 1;
    push(32'h11223344, 2'b00);
    push(32'h55667788, 2'b00);
    wait_starts(base + 2);
    enable = 1'b0;
    wait_wd(tgt);
    repeat (30) @(negedge clk);
    exp_sent += 16'd4;
    chk("en_pops", rd_cnt - rd_base, 1);
    chk("en_nstarts", start_log.size() - base, 4);
    chk_byte("en_b0", base, 8'h44);
    chk_byte("en_b3", base + 3, 8'h11);
    chk("en_idle", {31'd0, idle}, 32'd1);
    chk("en_fifo_left", fifo_q.size(), 1);
    chk("en_bytes_sent", {16'd0, bytes_sent}, {16'd0, exp_sent});

    // Reset during WAIT_DONE of byte 3
    base = start_log.size();
    enable = 1'b1;
    wait_starts(base + 3);
    k = 0;
    while (!tx_busy && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    exp_sent = '0;
    repeat (15) @(negedge clk);
    rst_n = 1'b1;
    base = start_log.size();
    tgt = wd_cnt + 1;
    push(32'hAABBCCDD, 2'b10);
    check_c3(8'hDD);
    wait_wd(tgt);
    repeat (2) @(negedge clk);
    exp_sent += 16'd2;
    chk_byte("post_rst_b1", base + 1, 8'hCC);
    chk("post_rst_bytes_sent", {16'd0, bytes_sent}, {16'd0, exp_sent});

    // Counter wrap
    @(negedge clk);
    force dut.bytes_sent_q = 16'hFFFF;
    #1 release dut.bytes_sent_q;
    @(negedge clk);
    chk("wrap_preload", {16'd0, bytes_sent}, 32'h0000FFFF);
    prev_cnt = bytes_sent;
    tgt = wd_cnt + 1;
    push(32'h00001357, 2'b10);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bytes_sent != prev_cnt) begin
        seen.push_back(bytes_sent);
        prev_cnt = bytes_sent;
      end
      if (wd_cnt >= tgt) break;
    end
    chk("wrap_nchanges", seen.size(), 2);
    if (seen.size() >= 2) begin
      chk("wrap_first", {16'd0, seen[0]}, 32'h00000000);
      chk("wrap_second", {16'd0, seen[1]}, 32'h00000001);
    end

    chk("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
